// File: rtl/fifo_rd_stage.sv
// FIFO read-side stage: pops a first-word-fall-through FIFO into a
// registered valid/ready stream through a 2-entry (head + skid) buffer.
//
// Ports:
//   rd_clk, rd_rst_n      clock, async active-low reset
//   fifo_rd_data          FIFO head word (valid while fifo_empty=0)
//   fifo_empty            FIFO empty flag
//   fifo_rd_en            pop strobe to the FIFO
//   flush                 synchronous discard of buffered words
//   m_data, m_valid       registered stream outputs
//   m_ready               downstream ready
//   cnt_clr, xfer_count   transfer counter, only with the
//                         FIFO_RD_STAGE_XFER_CNT_EN macro defined
module fifo_rd_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic                  flush,
`ifdef FIFO_RD_STAGE_XFER_CNT_EN
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  xfer_count,
`endif
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e                  occ;
    logic [DATA_WIDTH-1:0] entry1;
    logic                  push;
    logic                  pop;

    // The pop strobe looks only at local occupancy, never at m_ready,
    // so the FIFO never sees a combinational path from downstream.
    assign fifo_rd_en = ~fifo_empty & (occ != TWO) & ~flush & rd_rst_n;
    assign push       = fifo_rd_en;
    assign pop        = m_valid & m_ready;

    // m_data is entry0. m_valid is kept registered in lockstep with occ.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            occ     <= EMPTY;
            m_valid <= 1'b0;
            m_data  <= '0;
            entry1  <= '0;
        end else if (flush) begin
            occ     <= EMPTY;
            m_valid <= 1'b0;
        end else begin
            unique case (occ)
                EMPTY: begin
                    if (push) begin
                        m_data  <= fifo_rd_data;
                        occ     <= ONE;
                        m_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // head leaves as the new word lands in its place
                        m_data <= fifo_rd_data;
                    end else if (push) begin
                        entry1 <= fifo_rd_data;
                        occ    <= TWO;
                    end else if (pop) begin
                        occ     <= EMPTY;
                        m_valid <= 1'b0;
                    end
                end
                TWO: begin
                    // no push is possible here; skid word advances
                    if (pop) begin
                        m_data <= entry1;
                        occ    <= ONE;
                    end
                end
                default: begin
                    occ     <= EMPTY;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_RD_STAGE_XFER_CNT_EN
    // Clear wins over a coincident transfer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            xfer_count <= '0;
        end else if (cnt_clr) begin
            xfer_count <= '0;
        end else if (pop) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/fifo_rd_stage.md
FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL be the width of the FIFO read word and of m_data.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL be the width of xfer_count (used only with the Configuration feature).
REQ-003 rd_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rd_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 fifo_rd_data  input  DATA_WIDTH  SHALL be the FIFO head word, valid in the same cycle whenever fifo_empty=0.
REQ-006 fifo_empty  input  1  SHALL be the FIFO empty flag, in the rd_clk domain.
REQ-007 fifo_rd_en  output  1  SHALL be the pop strobe to the FIFO; one word is consumed per cycle it is high.
REQ-008 flush  input  1  SHALL be a synchronous discard of all buffered words.
REQ-009 m_data  output  DATA_WIDTH  SHALL be the stream data, driven from a register.
REQ-010 m_valid  output  1  SHALL be the stream valid, driven from a register.
REQ-011 m_ready  input  1  SHALL be the downstream ready; a transfer occurs on an edge where m_valid=1 and m_ready=1.

Function
REQ-012 The block SHALL hold a 2-entry buffer (entry0 = head, entry1 = skid) with occupancy occ in {0,1,2}, i.e. states EMPTY, ONE, TWO.
REQ-013 fifo_rd_en SHALL equal ~fifo_empty & (occ != 2) & ~flush & rd_rst_n; it SHALL NOT depend on m_ready.
REQ-014 push = fifo_rd_en; pop = m_valid & m_ready; occ SHALL update to occ + push - pop each edge.
REQ-015 Transitions: EMPTY->ONE on push; ONE->TWO on push&~pop; ONE->EMPTY on pop&~push; ONE stays on push&pop or neither; TWO->ONE on pop; TWO stays otherwise.
REQ-016 On push, fifo_rd_data SHALL be written to entry0 if (occ - pop) = 0, otherwise to entry1.
REQ-017 On pop with occ=2, entry1 SHALL move to entry0 on the same edge.
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL equal entry0.
REQ-019 Latency SHALL be one cycle: a word popped at edge N is on m_data with m_valid=1 after edge N.
REQ-020 Sustained throughput SHALL be one word per cycle when the FIFO is non-empty and m_ready=1.
REQ-021 m_data and m_valid SHALL remain stable while m_valid=1 and m_ready=0.
REQ-022 Words SHALL be delivered in FIFO order with no loss or duplication.
REQ-023 flush=1 SHALL set occ to 0 on the next edge, overriding any simultaneous push or pop; m_data SHALL hold its last value.

Reset
REQ-024 While rd_rst_n=0: occ=0, m_valid=0, m_data=0, entry1=0, fifo_rd_en=0, xfer_count=0 (if present).
REQ-025 Reset asserted mid-transfer SHALL discard all buffered words immediately; after release, operation SHALL resume from EMPTY.

Configuration
REQ-026 Macro FIFO_RD_STAGE_XFER_CNT_EN SHALL control the transfer counter.
REQ-027 With the macro defined: add input cnt_clr (1) and output xfer_count (CNT_WIDTH); xfer_count SHALL increment by 1 on each transfer and wrap from all-ones to 0.
REQ-028 With the macro defined: cnt_clr=1 SHALL zero xfer_count on the next edge; a transfer in the same cycle SHALL NOT be counted.
REQ-029 Without the macro: cnt_clr and xfer_count SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Reset then FIFO holding 0x11,0x22,0x33, m_ready=1 -> 0x11/0x22/0x33 on consecutive cycles, first one cycle after the first fifo_rd_en.
REQ-031 m_ready=0 with 5 words queued -> exactly 2 pops, then fifo_rd_en=0, m_data=first word held stable; m_ready=1 -> all 5 words in order.
REQ-032 Toggle m_ready every cycle for 20 words 0x00..0x13 -> output sequence 0x00..0x13 exactly once each.
REQ-033 occ=2 with flush=1 and fifo_empty=0 -> fifo_rd_en=0 that cycle, m_valid=0 next cycle, next word delivered is the FIFO head.
REQ-034 rd_rst_n pulsed low mid-stream with occ=2 -> m_valid=0 and fifo_rd_en=0 immediately, independent of rd_clk.
REQ-035 With FIFO_RD_STAGE_XFER_CNT_EN, CNT_WIDTH=4: 17 transfers -> xfer_count=1; cnt_clr coincident with a transfer -> xfer_count=0.
